// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the two-requester data bus arbiter.
//   - default address/data widths
//   - FSM state encodings (legacy 2-bit values kept for compatibility)
//   - reset value of the last-granted pointer
package data_bus_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ACC  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Pointer reset to requester 1 so requester 0 wins the first tie.
  localparam logic LAST_RST = 1'b1;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Requester-side bus of the data bus arbiter (one instance per requester).
//   master modport : the requester (drives req/we/addr/sel/wdata,
//                    receives gnt/ack/rdata)
//   slave modport  : the arbiter
interface data_bus_arbiter_if
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        sel;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, sel, wdata,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, we, addr, sel, wdata,
    output gnt, ack, rdata
  );

endinterface

// File: rtl/data_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker.
//   req[1:0] : pending requests
//   last     : index of the requester granted most recently
//   gnt[1:0] : one-hot winner (all zero when nothing is requested)
// A lone requester always wins; on a tie the one not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Data bus arbiter: two requesters share one single-cycle data RAM.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset
//   m0, m1     : requester buses (slave side)
//   ram_ce     : RAM access strobe, high only in ACC
//   ram_we     : RAM write strobe, high only in ACC for writes
//   ram_addr   : latched address of the access
//   ram_sel    : latched byte selects
//   ram_data_o : latched write data
//   ram_data_i : combinational read data from the RAM
// Each access takes IDLE -> ACC -> RESP; the winner's request fields are
// latched in IDLE, so later changes on the bus do not disturb the access.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  data_bus_arbiter_if.slave  m0,
  data_bus_arbiter_if.slave  m1,
  output logic               ram_ce,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [3:0]         ram_sel,
  output logic [DATA_W-1:0]  ram_data_o,
  input  logic [DATA_W-1:0]  ram_data_i
);

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        ack_q, ack_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0] req;
  logic [1:0] pick;

  assign req = {m1.req, m0.req};

  rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (pick)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    we_d     = we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          last_d  = pick[1];
          state_d = ST_ACC;
          if (pick[1]) begin
            we_d    = m1.we;
            addr_d  = m1.addr;
            sel_d   = m1.sel;
            wdata_d = m1.wdata;
          end else begin
            we_d    = m0.we;
            addr_d  = m0.addr;
            sel_d   = m0.sel;
            wdata_d = m0.wdata;
          end
        end
      end
      ST_ACC: begin
        state_d = ST_RESP;
        // ack is registered here so it appears exactly in RESP.
        ack_d   = gnt_q;
        if (!we_q) begin
          if (gnt_q[0]) rdata0_d = ram_data_i;
          if (gnt_q[1]) rdata1_d = ram_data_i;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      last_q   <= LAST_RST;
      gnt_q    <= '0;
      ack_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ram_ce     = (state_q == ST_ACC);
  assign ram_we     = (state_q == ST_ACC) & we_q;
  assign ram_addr   = addr_q;
  assign ram_sel    = sel_q;
  assign ram_data_o = wdata_q;

  assign m0.gnt   = gnt_q[0];
  assign m1.gnt   = gnt_q[1];
  assign m0.ack   = ack_q[0];
  assign m1.ack   = ack_q[1];
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have, for each requester x in {0,1}, these inputs:
- mx_req, 1 bit: request.
- mx_we, 1 bit: write enable.
- mx_addr, ADDR_W bits: address.
- mx_sel, 4 bits: byte select.
- mx_wdata, DATA_W bits: write data.
REQ-006 The block SHALL have, for each requester x, these outputs:
- mx_gnt, 1 bit: granted.
- mx_ack, 1 bit: completion pulse.
- mx_rdata, DATA_W bits: read data.
REQ-007 The block SHALL drive these outputs to the data RAM:
- ram_ce, 1 bit.
- ram_we, 1 bit.
- ram_addr, ADDR_W bits.
- ram_sel, 4 bits.
- ram_data_o, DATA_W bits.
REQ-008 The block SHALL have input ram_data_i, DATA_W bits: combinational read data from the RAM.

Function
REQ-009 The FSM SHALL have three states: IDLE, ACC, RESP.
REQ-010 In IDLE with no request pending, the FSM SHALL remain in IDLE.
REQ-011 In IDLE with at least one request pending, the FSM SHALL select a winner, latch that requester's we/addr/sel/wdata, assert its gnt registered, and go to ACC.
REQ-012 From ACC the FSM SHALL go to RESP unconditionally, and from RESP to IDLE unconditionally.
REQ-013 Arbitration SHALL be round-robin over two requesters:
- If only one requests, it wins.
- If both request, the requester not granted last wins.
REQ-014 The last-granted pointer SHALL update on every grant.
REQ-015 mx_gnt SHALL be high during ACC and RESP for the winner only, and the two gnt outputs SHALL never be high together.
REQ-016 In ACC, ram_ce SHALL be 1, and ram_we/addr/sel/data_o SHALL equal the latched request fields.
REQ-017 Outside ACC, ram_ce and ram_we SHALL be 0.
REQ-018 In ACC on a read, ram_data_i SHALL be captured into the winner's rdata register at the end of the cycle.
REQ-019 On a write, rdata SHALL keep its previous value.
REQ-020 mx_ack SHALL be a one-cycle pulse in RESP, for the winner only.
REQ-021 Latency SHALL be 3 cycles from req sampled in IDLE (cycle N) to ack (cycle N+2), giving a throughput of one access per 3 cycles.
REQ-022 A requester SHALL hold req and its fields until ack, then drop req on the following cycle; the arbiter SHALL sample req only in IDLE.
REQ-023 Changes to request fields after grant SHALL NOT affect the access in progress.
REQ-024 A request that arrives while the FSM is in ACC or RESP SHALL wait for IDLE and SHALL NOT be lost.
REQ-025 mx_rdata SHALL stay stable between acks.
REQ-026 Address and data SHALL pass through unmodified, with no width conversion or alignment checks.

Reset
REQ-027 When rst=0 at a clock edge, the block SHALL reset as follows:
- State goes to IDLE.
- All gnt, ack, ram_ce and ram_we outputs go to 0.
- ram_addr, ram_sel and ram_data_o go to 0.
- mx_rdata goes to 0.
- The last-granted pointer goes to 1, so m0 wins the first tie.
REQ-028 A reset asserted in ACC or RESP SHALL abort the transaction: no ack issued and no RAM write after the reset edge.
REQ-029 The first grant after reset release SHALL be possible in the first cycle with rst=1.

Structure
REQ-030 State encodings (IDLE=2'b00, ACC=2'b01, RESP=2'b10) and the default bus widths SHALL live in the shared definitions file.
REQ-031 The two-way round-robin picker SHALL be one sub-module, rr_pick2, with inputs req[1:0] and last, and output the one-hot grant.
REQ-032 The remainder, comprising the FSM, the latch, the RAM drive and the rdata registers, SHALL sit in data_bus_arbiter.

Verification
REQ-033 A bench SHALL show that m0 reading 0x100, with RAM word 0xDEADBEEF and m1 idle, gives m0_gnt at N+1, a ram_ce pulse at N+1, m0_ack at N+2 and m0_rdata=0xDEADBEEF.
REQ-034 A bench SHALL show that m0 and m1 requesting in the same cycle after reset are served m0 first, then m1, with the m1 ack 3 cycles after the m0 ack.
REQ-035 A bench SHALL show that with both requesting continuously for 4 transactions, grants alternate m0, m1, m0, m1.
REQ-036 A bench SHALL show that an m1 write of 0x12345678 to 0x200 with sel=4'b0011, followed by an m0 read of 0x200, returns 0x00005678 (lower bytes written, upper bytes still 0).
REQ-037 A bench SHALL show that rst=0 held for one cycle during ACC of an m0 write gives m0_ack never asserted, ram_we=0 from the reset edge onward, and all outputs 0.
REQ-038 A bench SHALL show that m1_addr changed from 0x300 to 0x304 during ACC still results in ram_addr=0x300 for that access.
